// File: rtl/circuit6_rom_if.sv
// Bus bundle for the 8-entry constant lookup: address in, combinational and
// registered words out.
interface circuit6_rom_if;
  logic [2:0]  a;
  logic [15:0] q;
  logic [15:0] q_r;

  modport master (
    output a,
    input  q,
    input  q_r
  );

  modport slave (
    input  a,
    output q,
    output q_r
  );
endinterface

// File: rtl/circuit6_rom.sv
// Fixed 8x16 lookup table: q is a zero-latency decode of a, q_r is the same
// word captured on the rising clock edge and cleared asynchronously by rst_n.
module circuit6_rom (
  input  logic            clk,
  input  logic            rst_n,
  circuit6_rom_if.slave   bus
);

  // Unknown addresses fall to the default so q never holds a stale word.
  function automatic logic [15:0] rom_word(input logic [2:0] addr);
    logic [15:0] word;
    case (addr)
      3'd0:    word = 16'h1232;
      3'd1:    word = 16'haee0;
      3'd2:    word = 16'h27d4;
      3'd3:    word = 16'h5a0e;
      3'd4:    word = 16'h2066;
      3'd5:    word = 16'h64ce;
      3'd6:    word = 16'hc526;
      3'd7:    word = 16'h2f19;
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  logic [15:0] q_d;
  logic [15:0] q_r_q;

  // Combinational decode feeding both the direct output and the register.
  always_comb begin
    q_d = 16'h0000;
    q_d = rom_word(bus.a);
  end

  // Registered copy with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r_q <= 16'h0000;
    end else begin
      q_r_q <= q_d;
    end
  end

  assign bus.q   = q_d;
  assign bus.q_r = q_r_q;

endmodule

// File: tb/tb_circuit6_rom.sv
// Self-checking bench for circuit6_rom: table-driven sweep of q plus a
// scoreboard of expected q_r words around reset and random traffic.
module tb_circuit6_rom;

  logic clk;
  logic rst_n;

  circuit6_rom_if bus ();

  circuit6_rom dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] q;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] tbl  [8];
  logic [15:0] sb_q [$];
  int          chk_cnt;
  int          pass_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Pop the oldest expected registered word and compare it with q_r.
  task automatic sb_check(input string name);
    logic [15:0] exp;
    if (sb_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL %s: scoreboard empty, got %h expected a queued word", name, bus.q_r);
    end else begin
      exp = sb_q.pop_front();
      chk(name, bus.q_r, exp);
    end
  endtask

  // Drive a between edges, check q at once, then q_r after the next rising edge.
  task automatic drive_reg(input logic [2:0] addr, input string name);
    @(negedge clk);
    bus.a = addr;
    sb_q.push_back(tbl[addr]);
    #1;
    chk({name, "_q"}, bus.q, tbl[addr]);
    @(posedge clk);
    #1;
    sb_check({name, "_qr"});
  endtask

  initial begin
    logic [2:0] r;
    chk_cnt  = 0;
    pass_cnt = 0;

    tbl[0] = 16'h1232; tbl[1] = 16'haee0; tbl[2] = 16'h27d4; tbl[3] = 16'h5a0e;
    tbl[4] = 16'h2066; tbl[5] = 16'h64ce; tbl[6] = 16'hc526; tbl[7] = 16'h2f19;

    vecs[0]  = '{3'd0, 16'h1232};
    vecs[1]  = '{3'd1, 16'haee0};
    vecs[2]  = '{3'd2, 16'h27d4};
    vecs[3]  = '{3'd3, 16'h5a0e};
    vecs[4]  = '{3'd4, 16'h2066};
    vecs[5]  = '{3'd5, 16'h64ce};
    vecs[6]  = '{3'd6, 16'hc526};
    vecs[7]  = '{3'd7, 16'h2f19};
    vecs[8]  = '{3'd0, 16'h1232};
    vecs[9]  = '{3'd1, 16'haee0};
    vecs[10] = '{3'd2, 16'h27d4};

    rst_n = 1'b0;
    bus.a = 3'd4;
    #1;
    chk("reset_qr", bus.q_r, 16'h0000);
    chk("reset_q", bus.q, 16'h2066);
    #2;
    rst_n = 1'b1;

    // Sweep with wrap, changing a right at alternating clock edges.
    for (int i = 0; i < 11; i++) begin
      if ((i % 2) == 0) begin
        @(negedge clk);
      end else begin
        @(posedge clk);
      end
      bus.a = vecs[i].a;
      #1;
      chk($sformatf("sweep_q[%0d]", i), bus.q, vecs[i].q);
    end

    // Reset held: q still decodes, q_r stays clear, first edge after release loads.
    @(negedge clk);
    rst_n = 1'b0;
    bus.a = 3'd5;
    #1;
    chk("rst_hold_q", bus.q, 16'h64ce);
    chk("rst_hold_qr", bus.q_r, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_hold_edge_qr", bus.q_r, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_qr", bus.q_r, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_first_load_qr", bus.q_r, 16'h64ce);

    drive_reg(3'd3, "seq3");
    drive_reg(3'd6, "seq6");
    drive_reg(3'd1, "seq1");

    // Mid-operation reset between edges with q_r = aee0.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_qr", bus.q_r, 16'h0000);
    chk("mid_rst_q", bus.q, 16'haee0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: updates after both edges; only the negedge value is captured.
    for (int i = 0; i < 60; i++) begin
      r = 3'($urandom_range(0, 7));
      drive_reg(r, $sformatf("rnd_neg[%0d]", i));
      #1;
      r = 3'($urandom_range(0, 7));
      bus.a = r;
      #1;
      chk($sformatf("rnd_pos_q[%0d]", i), bus.q, tbl[r]);
    end

    if (sb_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL sb_drain: %0d words left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
